axis_pkt_fifobuf: RTL and testbench

- AXI-stream FIFO buffer with TLAST support and a selectable cut-through or store-and-forward (packet) mode.
- Sits between a bursty producer (e.g. SRAM read path, pixel stream) and a consumer that needs whole packets or steady flow.
- Adds occupancy and packet-count status outputs.
- Keeps an almost-full backpressure margin so upstream pipelines with one cycle of ready lag never overflow.

---
 rtl/axis_pkt_fifobuf.sv | 140 ++++++++++++++
 tb/tb_axis_pkt_fifobuf.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_fifobuf.sv
// AXI-stream FIFO with a registered first-word-fall-through output stage, TLAST tracking,
// and an optional store-and-forward mode with an oversize-packet escape.
module axis_pkt_fifobuf #(
    parameter int DATA_WIDTH           = 8,
    parameter int FIFO_ADDR_SIZE       = 4,
    parameter int FIFO_ALMOST_FULL_BUF = 4,
    parameter int PACKET_MODE          = 0
) (
    input  logic                      axi_clk,
    input  logic                      axi_resetn,
    input  logic                      s_axi_tvalid,
    output logic                      s_axi_tready,
    input  logic [DATA_WIDTH-1:0]     s_axi_tdata,
    input  logic                      s_axi_tlast,
    output logic                      m_axi_tvalid,
    input  logic                      m_axi_tready,
    output logic [DATA_WIDTH-1:0]     m_axi_tdata,
    output logic                      m_axi_tlast,
    output logic [FIFO_ADDR_SIZE:0]   level,
    output logic [FIFO_ADDR_SIZE:0]   pkt_count
);

    localparam int AW     = FIFO_ADDR_SIZE;
    localparam int DEPTH  = 1 << AW;
    localparam int THRESH = DEPTH - FIFO_ALMOST_FULL_BUF;
    localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_L = (AW+1)'(THRESH);
    localparam bit PKT_MODE = (PACKET_MODE != 0);

    logic [DATA_WIDTH:0]   mem_q [DEPTH];

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]           level_q, level_d;
    logic [AW:0]           pkt_q, pkt_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic                  s_ready_q, s_ready_d;
    logic                  release_q, release_d;

    logic [AW:0]           mem_cnt;
    logic                  in_acc, out_xfer, out_free, load_ok;
    logic                  load_mem, load_byp, mem_wr;
    logic                  in_last, out_last;

    // Writes are taken up to true full, not just THRESH, so a lagging producer never loses beats.
    always_comb begin
        mem_cnt  = wr_ptr_q - rd_ptr_q;
        in_acc   = s_axi_tvalid && (level_q < DEPTH_L);
        out_xfer = m_valid_q && m_axi_tready;
        out_free = !m_valid_q || out_xfer;
        load_ok  = !PKT_MODE || (pkt_q != '0) || release_q;
        load_mem = out_free && (mem_cnt != '0) && load_ok;
        load_byp = out_xfer && (mem_cnt == '0) && in_acc && load_ok;
        mem_wr   = in_acc && !load_byp;
        in_last  = in_acc && s_axi_tlast;
        out_last = out_xfer && m_last_q;

        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, mem_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, load_mem};

        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        if (load_mem) begin
            {m_last_d, m_data_d} = mem_q[rd_ptr_q[AW-1:0]];
        end else if (load_byp) begin
            m_data_d = s_axi_tdata;
            m_last_d = s_axi_tlast;
        end
        if (load_mem || load_byp) begin
            m_valid_d = 1'b1;
        end else if (out_xfer) begin
            m_valid_d = 1'b0;
        end

        level_d = level_q;
        if (in_acc && !out_xfer) begin
            level_d = level_q + 1'b1;
        end else if (!in_acc && out_xfer) begin
            level_d = level_q - 1'b1;
        end

        pkt_d = pkt_q;
        if (in_last && !out_last) begin
            pkt_d = pkt_q + 1'b1;
        end else if (!in_last && out_last) begin
            pkt_d = pkt_q - 1'b1;
        end

        s_ready_d = (level_d < THRESH_L);

        // A packet too large to ever complete in storage falls back to cut-through until its tlast leaves.
        release_d = release_q;
        if (out_last) begin
            release_d = 1'b0;
        end else if ((level_q >= THRESH_L) && (pkt_q == '0)) begin
            release_d = 1'b1;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (mem_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_axi_tlast, s_axi_tdata};
        end
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pkt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            s_ready_q <= 1'b0;
            release_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            pkt_q     <= pkt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            s_ready_q <= s_ready_d;
            release_q <= release_d;
        end
    end

    assign s_axi_tready = s_ready_q;
    assign m_axi_tvalid = m_valid_q;
    assign m_axi_tdata  = m_data_q;
    assign m_axi_tlast  = m_last_q;
    assign level        = level_q;
    assign pkt_count    = pkt_q;

endmodule

// File: tb/tb_axis_pkt_fifobuf.sv
// Directed bench for axis_pkt_fifobuf: one cut-through and one store-and-forward instance share stimulus.
module tb_axis_pkt_fifobuf;

    logic       axi_clk = 1'b0;
    logic       axi_resetn;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_ready;

    logic       ct_s_ready, ct_m_valid, ct_m_last;
    logic [7:0] ct_m_data;
    logic [4:0] ct_level, ct_pkt;
    logic       pk_s_ready, pk_m_valid, pk_m_last;
    logic [7:0] pk_m_data;
    logic [4:0] pk_level, pk_pkt;

    logic       pm;
    logic       obs_s_ready, obs_m_valid, obs_m_last;
    logic [7:0] obs_m_data;
    logic [4:0] obs_level, obs_pkt;

    int         num_checks = 0;
    int         num_fail   = 0;
    bit         mon_en     = 1'b0;
    logic [8:0] exp_q [$];

    always #5 axi_clk = ~axi_clk;

    axis_pkt_fifobuf #(.DATA_WIDTH(8), .FIFO_ADDR_SIZE(4), .FIFO_ALMOST_FULL_BUF(4), .PACKET_MODE(0)) u_dut_ct (
        .axi_clk(axi_clk), .axi_resetn(axi_resetn),
        .s_axi_tvalid(s_valid), .s_axi_tready(ct_s_ready), .s_axi_tdata(s_data), .s_axi_tlast(s_last),
        .m_axi_tvalid(ct_m_valid), .m_axi_tready(m_ready), .m_axi_tdata(ct_m_data), .m_axi_tlast(ct_m_last),
        .level(ct_level), .pkt_count(ct_pkt)
    );

    axis_pkt_fifobuf #(.DATA_WIDTH(8), .FIFO_ADDR_SIZE(4), .FIFO_ALMOST_FULL_BUF(4), .PACKET_MODE(1)) u_dut_pkt (
        .axi_clk(axi_clk), .axi_resetn(axi_resetn),
        .s_axi_tvalid(s_valid), .s_axi_tready(pk_s_ready), .s_axi_tdata(s_data), .s_axi_tlast(s_last),
        .m_axi_tvalid(pk_m_valid), .m_axi_tready(m_ready), .m_axi_tdata(pk_m_data), .m_axi_tlast(pk_m_last),
        .level(pk_level), .pkt_count(pk_pkt)
    );

    always_comb begin
        obs_s_ready = pm ? pk_s_ready : ct_s_ready;
        obs_m_valid = pm ? pk_m_valid : ct_m_valid;
        obs_m_data  = pm ? pk_m_data  : ct_m_data;
        obs_m_last  = pm ? pk_m_last  : ct_m_last;
        obs_level   = pm ? pk_level   : ct_level;
        obs_pkt     = pm ? pk_pkt     : ct_pkt;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled on the falling edge; a beat seen valid&ready there transfers at the next rising edge.
    task automatic tick();
        logic [8:0] exp_word;
        @(negedge axi_clk);
        if (mon_en && obs_m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_beat", 32'(obs_m_valid), 32'(0));
            end else begin
                exp_word = exp_q.pop_front();
                checkOutput("out_beat", 32'({obs_m_last, obs_m_data}), 32'(exp_word));
            end
        end
        @(posedge axi_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input bit track);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        tick();
        if (v && track) exp_q.push_back({l, d});
        s_valid = 1'b0;
    endtask

    task automatic drainAll(input int max_cycles);
        int n = 0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            tick();
            n++;
        end
        checkOutput("drain_timeout", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic doReset();
        mon_en     = 1'b0;
        axi_resetn = 1'b0;
        s_valid    = 1'b0;
        m_ready    = 1'b0;
        tick();
        tick();
        exp_q.delete();
        checkOutput("rst_level", 32'(obs_level), 32'(0));
        checkOutput("rst_pkt", 32'(obs_pkt), 32'(0));
        checkOutput("rst_mvalid", 32'(obs_m_valid), 32'(0));
        checkOutput("rst_mdata", 32'(obs_m_data), 32'(0));
        checkOutput("rst_mlast", 32'(obs_m_last), 32'(0));
        checkOutput("rst_tready", 32'(obs_s_ready), 32'(0));
        axi_resetn = 1'b1;
        tick();
        checkOutput("post_rst_tready", 32'(obs_s_ready), 32'(1));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        pm = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0; axi_resetn = 1'b0;

        // Single beat: two-edge latency into the output register, then drained.
        doReset();
        applyStimulus(1'b1, 8'hA1, 1'b1, 1'b0);
        checkOutput("t1_level_acc", 32'(obs_level), 32'(1));
        checkOutput("t1_mvalid_acc", 32'(obs_m_valid), 32'(0));
        tick();
        checkOutput("t1_mvalid", 32'(obs_m_valid), 32'(1));
        checkOutput("t1_mdata", 32'({obs_m_last, obs_m_data}), 32'(9'h1A1));
        checkOutput("t1_level", 32'(obs_level), 32'(1));
        checkOutput("t1_pkt", 32'(obs_pkt), 32'(1));
        m_ready = 1'b1;
        tick();
        checkOutput("t1_empty_mvalid", 32'(obs_m_valid), 32'(0));
        checkOutput("t1_empty_level", 32'(obs_level), 32'(0));
        checkOutput("t1_empty_pkt", 32'(obs_pkt), 32'(0));
        m_ready = 1'b0;

        // Fill to threshold, then drain with tready recovering at level 11.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
            if (i == 10) checkOutput("t2_tready_at11", 32'(obs_s_ready), 32'(1));
        end
        checkOutput("t2_level12", 32'(obs_level), 32'(12));
        checkOutput("t2_tready_at12", 32'(obs_s_ready), 32'(0));
        m_ready = 1'b1;
        checkOutput("t2_out0", 32'(obs_m_data), 32'(8'hA0));
        tick();
        checkOutput("t2_out1", 32'(obs_m_data), 32'(8'hA1));
        checkOutput("t2_level11", 32'(obs_level), 32'(11));
        checkOutput("t2_tready_back", 32'(obs_s_ready), 32'(1));
        tick();
        checkOutput("t2_out2", 32'(obs_m_data), 32'(8'hA2));
        checkOutput("t2_level10", 32'(obs_level), 32'(10));
        repeat (10) tick();
        checkOutput("t2_drained_mvalid", 32'(obs_m_valid), 32'(0));
        checkOutput("t2_drained_level", 32'(obs_level), 32'(0));

        // Producer ignores tready past threshold: all 16 beats must be kept, a 17th refused.
        m_ready = 1'b0;
        mon_en  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'h30 + i), (i % 4 == 3), 1'b1);
        end
        checkOutput("t3_level16", 32'(obs_level), 32'(16));
        checkOutput("t3_pkt4", 32'(obs_pkt), 32'(4));
        checkOutput("t3_tready_full", 32'(obs_s_ready), 32'(0));
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
        checkOutput("t3_full_refuse", 32'(obs_level), 32'(16));
        checkOutput("t3_full_refuse_pkt", 32'(obs_pkt), 32'(4));
        m_ready = 1'b1;
        drainAll(40);
        checkOutput("t3_end_level", 32'(obs_level), 32'(0));
        checkOutput("t3_end_pkt", 32'(obs_pkt), 32'(0));
        checkOutput("t3_end_mvalid", 32'(obs_m_valid), 32'(0));

        // Store-and-forward: nothing leaves until the tlast beat is in.
        pm = 1'b1;
        doReset();
        m_ready = 1'b1;
        mon_en  = 1'b1;
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b1);
        checkOutput("t4_hold0", 32'(obs_m_valid), 32'(0));
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b1);
        checkOutput("t4_hold1", 32'(obs_m_valid), 32'(0));
        applyStimulus(1'b1, 8'h12, 1'b1, 1'b1);
        checkOutput("t4_hold2", 32'(obs_m_valid), 32'(0));
        checkOutput("t4_pkt1", 32'(obs_pkt), 32'(1));
        tick();
        checkOutput("t4_first", 32'({obs_m_valid, obs_m_last, obs_m_data}), 32'(10'h210));
        drainAll(10);
        tick();
        checkOutput("t4_end_mvalid", 32'(obs_m_valid), 32'(0));
        checkOutput("t4_end_pkt", 32'(obs_pkt), 32'(0));

        // Oversize packet: release opens the output at level 12, closes after tlast.
        doReset();
        m_ready = 1'b1;
        mon_en  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'(8'h50 + i), (i == 19), 1'b1);
            if (i == 11) begin
                checkOutput("t5_level12", 32'(obs_level), 32'(12));
                checkOutput("t5_gated12", 32'(obs_m_valid), 32'(0));
            end
            if (i == 12) checkOutput("t5_gated13", 32'(obs_m_valid), 32'(0));
            if (i == 13) begin
                checkOutput("t5_released", 32'(obs_m_valid), 32'(1));
                checkOutput("t5_level14", 32'(obs_level), 32'(14));
            end
        end
        drainAll(40);
        checkOutput("t5_end_level", 32'(obs_level), 32'(0));
        checkOutput("t5_end_pkt", 32'(obs_pkt), 32'(0));
        applyStimulus(1'b1, 8'h70, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h71, 1'b0, 1'b1);
        repeat (4) tick();
        checkOutput("t5_regated", 32'(obs_m_valid), 32'(0));
        checkOutput("t5_regated_level", 32'(obs_level), 32'(2));

        // Steady streaming holds level constant; reset mid-stream flushes everything.
        pm = 1'b0;
        doReset();
        m_ready = 1'b1;
        mon_en  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, 8'(8'h80 + i), (i % 5 == 4), 1'b1);
            if (i == 5 || i == 15 || i == 25) checkOutput("t6_steady_level", 32'(obs_level), 32'(2));
        end
        s_valid    = 1'b1;
        s_data     = 8'hFF;
        s_last     = 1'b1;
        axi_resetn = 1'b0;
        tick();
        tick();
        exp_q.delete();
        checkOutput("t6_rst_level", 32'(obs_level), 32'(0));
        checkOutput("t6_rst_pkt", 32'(obs_pkt), 32'(0));
        checkOutput("t6_rst_mvalid", 32'(obs_m_valid), 32'(0));
        checkOutput("t6_rst_mdata", 32'(obs_m_data), 32'(0));
        s_valid    = 1'b0;
        axi_resetn = 1'b1;
        repeat (5) tick();
        checkOutput("t6_no_stale", 32'(obs_m_valid), 32'(0));
        checkOutput("t6_no_stale_level", 32'(obs_level), 32'(0));
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1);
        drainAll(10);
        tick();
        checkOutput("t6_final_level", 32'(obs_level), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
